// File: rtl/hsv_stream_ctrl_if.sv
// Bus bundle between the pixel source, the RGB->HSV converter and the threshold stage.
// The master modport is the stream controller's view. The slave modport is the environment's view.
interface hsv_stream_ctrl_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_r;
  logic [7:0] s_g;
  logic [7:0] s_b;
  logic       s_sop;
  logic       s_eop;

  logic       cvt_rst_n;
  logic       cvt_valid_in;
  logic [7:0] cvt_r;
  logic [7:0] cvt_g;
  logic [7:0] cvt_b;
  logic       cvt_valid_out;
  logic [8:0] cvt_h;
  logic [7:0] cvt_s;
  logic [7:0] cvt_v;

  logic       m_valid;
  logic       m_ready;
  logic [8:0] m_h;
  logic [7:0] m_s;
  logic [7:0] m_v;
  logic       m_sop;
  logic       m_eop;

  modport master (
    input  s_valid, s_r, s_g, s_b, s_sop, s_eop,
    output s_ready,
    output cvt_rst_n, cvt_valid_in, cvt_r, cvt_g, cvt_b,
    input  cvt_valid_out, cvt_h, cvt_s, cvt_v,
    output m_valid, m_h, m_s, m_v, m_sop, m_eop,
    input  m_ready
  );

  modport slave (
    output s_valid, s_r, s_g, s_b, s_sop, s_eop,
    input  s_ready,
    input  cvt_rst_n, cvt_valid_in, cvt_r, cvt_g, cvt_b,
    output cvt_valid_out, cvt_h, cvt_s, cvt_v,
    input  m_valid, m_h, m_s, m_v, m_sop, m_eop,
    output m_ready
  );
endinterface

// File: rtl/hsv_stream_ctrl.sv
// Credit-gated ready/valid wrapper around a fixed-latency, non-stallable RGB->HSV converter.
// Optional statistics counters are built only when HSV_STREAM_CTRL_STATS_EN is defined.
module hsv_stream_ctrl #(
  parameter int LATENCY      = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               soft_flush,
  hsv_stream_ctrl_if.master  bus,
  output logic               busy,
  output logic               err_sync,
  output logic [31:0]        stat_pix_cnt,
  output logic [15:0]        stat_frame_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {ST_FLUSH, ST_RUN, ST_DRAIN} state_t;

  typedef struct packed {
    logic [8:0] h;
    logic [7:0] s;
    logic [7:0] v;
    logic       sop;
    logic       eop;
  } entry_t;

  state_t          state, state_nxt;
  logic [FW-1:0]   flush_cnt, flush_cnt_nxt;
  logic [CW-1:0]   in_flight, fifo_count;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  entry_t          mem [FIFO_DEPTH];
  logic [2:0]      dl [LATENCY];
  logic            cvt_vld_q, sop_q, eop_q;
  logic [7:0]      r_q, g_q, b_q;
  logic            ready, cvt_rst_n_c, accept;
  logic            tap_vld, tap_sop, tap_eop;
  logic            fifo_full, push_ok, pop, out_vld;
  logic [CW:0]     credit_used;
  entry_t          head;

  assign credit_used = {1'b0, in_flight} + {1'b0, fifo_count};
  assign accept      = bus.s_valid & ready;
  assign {tap_vld, tap_sop, tap_eop} = dl[LATENCY-1];
  assign fifo_full   = (fifo_count == CW'(FIFO_DEPTH));
  assign push_ok     = tap_vld & ~fifo_full;
  assign out_vld     = (fifo_count != '0);
  assign pop         = out_vld & bus.m_ready;
  assign head        = mem[rd_ptr];

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    ready         = 1'b0;
    cvt_rst_n_c   = 1'b1;
    case (state)
      ST_FLUSH: begin
        cvt_rst_n_c = 1'b0;
        if (flush_cnt == FW'(FLUSH_CYCLES - 1)) begin
          state_nxt     = ST_RUN;
          flush_cnt_nxt = '0;
        end else begin
          flush_cnt_nxt = flush_cnt + FW'(1);
        end
      end
      ST_RUN: begin
        // soft_flush closes the input in the same cycle it is seen
        if (soft_flush) state_nxt = ST_DRAIN;
        else            ready     = (credit_used < (CW+1)'(FIFO_DEPTH));
      end
      ST_DRAIN: begin
        if (in_flight == '0 && fifo_count == '0) begin
          state_nxt     = ST_FLUSH;
          flush_cnt_nxt = '0;
        end
      end
      default: state_nxt = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FLUSH;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cvt_vld_q <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      cvt_vld_q <= accept;
      if (accept) begin
        r_q   <= bus.s_r;
        g_q   <= bus.s_g;
        b_q   <= bus.s_b;
        sop_q <= bus.s_sop;
        eop_q <= bus.s_eop;
      end
    end
  end

  // Tap lines up with the converter's valid_out: LATENCY stages behind cvt_valid_in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) dl[i] <= '0;
    end else begin
      dl[0] <= {cvt_vld_q, sop_q, eop_q};
      for (int i = 1; i < LATENCY; i++) dl[i] <= dl[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight  <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_sync   <= 1'b0;
    end else begin
      case ({accept, tap_vld})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: ;
      endcase
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if ((bus.cvt_valid_out != tap_vld) || (tap_vld && fifo_full))
        err_sync <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= '{h: bus.cvt_h, s: bus.cvt_s, v: bus.cvt_v, sop: tap_sop, eop: tap_eop};
  end

  assign bus.s_ready      = ready;
  assign bus.cvt_rst_n    = cvt_rst_n_c;
  assign bus.cvt_valid_in = cvt_vld_q;
  assign bus.cvt_r        = r_q;
  assign bus.cvt_g        = g_q;
  assign bus.cvt_b        = b_q;
  // Payload is gated so that unwritten storage never reaches the outputs
  assign bus.m_valid      = out_vld;
  assign bus.m_h          = out_vld ? head.h   : '0;
  assign bus.m_s          = out_vld ? head.s   : '0;
  assign bus.m_v          = out_vld ? head.v   : '0;
  assign bus.m_sop        = out_vld ? head.sop : 1'b0;
  assign bus.m_eop        = out_vld ? head.eop : 1'b0;

  assign busy = (state != ST_RUN) || (in_flight != '0) || out_vld;

`ifdef HSV_STREAM_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pix_cnt   <= '0;
      stat_frame_cnt <= '0;
    end else if (pop) begin
      stat_pix_cnt <= stat_pix_cnt + 32'd1;
      if (head.eop) stat_frame_cnt <= stat_frame_cnt + 16'd1;
    end
  end
`else
  assign stat_pix_cnt   = '0;
  assign stat_frame_cnt = '0;
`endif

endmodule
